// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for a single-port memory.
// Ports: clk, rst (async, active-high).
//   Requester side, per port X in {0,1}: i_reqX/i_weX/i_addrX/i_wdataX command in,
//   o_gntX accept pulse, o_rvalidX pulse with o_rdataX (held until next read of that port).
//   Memory side: o_mem_wr, o_mem_rd, o_mem_addr, io_mem_data (driven only while o_mem_wr=1).
// Config: define MEM_ARB_FIXED_PRIO_EN to make port 0 always win ties instead of round robin.
module mem_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [AWIDTH-1:0] i_addr0,
    input  logic [AWIDTH-1:0] i_addr1,
    input  logic [DWIDTH-1:0] i_wdata0,
    input  logic [DWIDTH-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DWIDTH-1:0] o_rdata0,
    output logic [DWIDTH-1:0] o_rdata1,
    output logic              o_mem_wr,
    output logic              o_mem_rd,
    output logic [AWIDTH-1:0] o_mem_addr,
    inout  wire  [DWIDTH-1:0] io_mem_data
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, READ_CAP} state_t;
    state_t            r_state;
    logic              r_own;
    logic              r_wr;
    logic              r_rd;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_rdata0;
    logic [DWIDTH-1:0] r_rdata1;
    logic              w_pick1;
    logic              w_we;
`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_pick1 = ~i_req0;
`else
    logic              r_last;
    // on a tie the port that was not granted last time wins
    assign w_pick1 = i_req1 & (~i_req0 | ~r_last);
`endif
    assign w_we        = w_pick1 ? i_we1 : i_we0;
    assign o_gnt0      = r_gnt0;
    assign o_gnt1      = r_gnt1;
    assign o_rvalid0   = r_rvalid0;
    assign o_rvalid1   = r_rvalid1;
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;
    assign o_mem_wr    = r_wr;
    assign o_mem_rd    = r_rd;
    assign o_mem_addr  = r_addr;
    assign io_mem_data = r_wr ? r_wdata : {DWIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_own     <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
            r_last    <= 1'b1;
`endif
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                IDLE: if (i_req0 | i_req1) begin
                    r_own   <= w_pick1;
                    r_addr  <= w_pick1 ? i_addr1 : i_addr0;
                    r_wdata <= w_pick1 ? i_wdata1 : i_wdata0;
                    r_gnt0  <= ~w_pick1;
                    r_gnt1  <= w_pick1;
                    r_wr    <= w_we;
                    r_rd    <= ~w_we;
                    r_state <= w_we ? WRITE : READ;
`ifdef MEM_ARB_FIXED_PRIO_EN
`else
                    r_last  <= w_pick1;
`endif
                end
                WRITE: begin
                    r_wr    <= 1'b0;
                    r_state <= IDLE;
                end
                // rd stays high through READ_CAP so registered memories have a cycle to respond
                READ: r_state <= READ_CAP;
                READ_CAP: begin
                    r_rd      <= 1'b0;
                    r_rvalid0 <= ~r_own;
                    r_rvalid1 <= r_own;
                    if (r_own) r_rdata1 <= io_mem_data;
                    else r_rdata0 <= io_mem_data;
                    r_state   <= IDLE;
                end
            endcase
        end
    end
endmodule
